// File: rtl/uwasic_onboarding_eliot_tong_if.sv
// -----------------------------------------------------------------------------
// uwasic_onboarding_eliot_tong_if
// Pin bundle of the UWASIC onboarding Tiny Tapeout block.
//   ena      : design selected (unused by the block)
//   ui_in    : [0]=SCLK, [1]=COPI, [2]=nCS (active-low), [7:3] unused
//   uio_in   : unused
//   uo_out   : output channels 7..0
//   uio_out  : output channels 15..8
//   uio_oe   : bidirectional pin output enables (all outputs)
// The master modport is the pad/harness side, the slave modport is the block.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uwasic_onboarding_eliot_tong_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/uwasic_onboarding_eliot_tong.sv
// -----------------------------------------------------------------------------
// uwasic_onboarding_eliot_tong
// SPI-configured 16-channel output driver with optional shared PWM.
//
// An SPI peripheral (mode 0, MSB first, 16-bit frames: R/W, 7-bit address,
// 8-bit data) writes five 8-bit registers:
//   0x00 en_out[7:0]   0x01 en_out[15:8]
//   0x02 en_pwm[7:0]   0x03 en_pwm[15:8]   0x04 duty
// Channel i drives en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
//
// Ports:
//   clk   : system clock (10 MHz nominal)
//   rst_n : asynchronous reset, ACTIVE-HIGH despite its name (pinout legacy)
//   bus   : pin bundle (slave modport), see uwasic_onboarding_eliot_tong_if
//
// Configuration macro:
//   PWM_EN : when defined, the PWM prescaler/counter and the en_pwm/duty
//            registers exist. When undefined, addresses 0x02-0x04 are
//            ignored and each channel simply follows en_out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uwasic_onboarding_eliot_tong (
    input  logic                           clk,
    input  logic                           rst_n,
    uwasic_onboarding_eliot_tong_if.slave  bus
);

    // ---------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------
    logic [1:0] sclk_sync_r;
    logic [1:0] copi_sync_r;
    logic [1:0] ncs_sync_r;
    logic       sclk_prev_r;
    logic       ncs_prev_r;

    logic       sclk_s;
    logic       copi_s;
    logic       ncs_s;
    logic       sclk_rise_s;
    logic       ncs_fall_s;
    logic       ncs_rise_s;

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sclk_sync_r <= 2'b00;
            copi_sync_r <= 2'b00;
            ncs_sync_r  <= 2'b00;
            sclk_prev_r <= 1'b0;
            ncs_prev_r  <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], bus.ui_in[0]};
            copi_sync_r <= {copi_sync_r[0], bus.ui_in[1]};
            ncs_sync_r  <= {ncs_sync_r[0],  bus.ui_in[2]};
            sclk_prev_r <= sclk_sync_r[1];
            ncs_prev_r  <= ncs_sync_r[1];
        end
    end

    assign sclk_s      = sclk_sync_r[1];
    assign copi_s      = copi_sync_r[1];
    assign ncs_s       = ncs_sync_r[1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign ncs_fall_s  = ~ncs_s & ncs_prev_r;
    assign ncs_rise_s  = ncs_s & ~ncs_prev_r;

    // ---------------------------------------------------------------
    // SPI frame capture
    // ---------------------------------------------------------------
    // bit_cnt saturates at 17 so any over-length frame stays invalid.
    logic [4:0]  bit_cnt_r;
    logic [15:0] shift_r;
    logic        commit_s;
    logic [6:0]  addr_s;
    logic [7:0]  data_s;

    // Bit counter and shift register; cleared at frame start
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if (ncs_fall_s) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if (!ncs_s && sclk_rise_s) begin
            shift_r <= {shift_r[14:0], copi_s};
            if (bit_cnt_r == 5'd17) begin
                bit_cnt_r <= 5'd17;
            end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
        end
    end

    assign addr_s   = shift_r[14:8];
    assign data_s   = shift_r[7:0];
    // Commit only a complete write frame at nCS release.
    assign commit_s = ncs_rise_s && (bit_cnt_r == 5'd16) && shift_r[15];

    // ---------------------------------------------------------------
    // Configuration registers
    // ---------------------------------------------------------------
    logic [15:0] en_out_r;
`ifdef PWM_EN
    logic [15:0] en_pwm_r;
    logic [7:0]  duty_r;
`endif

    // Register file write port
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            en_out_r <= 16'h0000;
`ifdef PWM_EN
            en_pwm_r <= 16'h0000;
            duty_r   <= 8'h00;
`endif
        end else if (commit_s) begin
            case (addr_s)
                7'h00:   en_out_r[7:0]  <= data_s;
                7'h01:   en_out_r[15:8] <= data_s;
`ifdef PWM_EN
                7'h02:   en_pwm_r[7:0]  <= data_s;
                7'h03:   en_pwm_r[15:8] <= data_s;
                7'h04:   duty_r         <= data_s;
`endif
                default: en_out_r <= en_out_r;
            endcase
        end else begin
            en_out_r <= en_out_r;
        end
    end

    // ---------------------------------------------------------------
    // PWM generator and channel mixing
    // ---------------------------------------------------------------
    logic [15:0] out_s;

`ifdef PWM_EN
    logic [3:0] presc_r;
    logic [7:0] pwm_cnt_r;
    logic       pwm_s;

    // Free-running divide-by-13 prescaler feeding the 8-bit PWM counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc_r   <= 4'd0;
            pwm_cnt_r <= 8'd0;
        end else if (presc_r == 4'd12) begin
            presc_r   <= 4'd0;
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end else begin
            presc_r   <= presc_r + 4'd1;
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // PWM compare; duty 0xFF is forced fully on (count < 255 misses one step)
    always_comb begin
        pwm_s = 1'b0;
        if (duty_r == 8'hFF) begin
            pwm_s = 1'b1;
        end else begin
            pwm_s = (pwm_cnt_r < duty_r);
        end
    end

    // Channel mix: enabled channels are steady high unless PWM-modulated
    always_comb begin
        out_s = en_out_r & (~en_pwm_r | {16{pwm_s}});
    end
`else
    // Channel mix without PWM: each channel follows its enable bit
    always_comb begin
        out_s = en_out_r;
    end
`endif

    // ---------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------
    logic [7:0] uo_out_r;
    logic [7:0] uio_out_r;

    // Output pin registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            uo_out_r  <= 8'h00;
            uio_out_r <= 8'h00;
        end else begin
            uo_out_r  <= out_s[7:0];
            uio_out_r <= out_s[15:8];
        end
    end

    assign bus.uo_out  = uo_out_r;
    assign bus.uio_out = uio_out_r;
    assign bus.uio_oe  = 8'hFF;

    // Inputs the block deliberately ignores.
    logic unused_s;
    assign unused_s = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_eliot_tong.sv
`timescale 1ns/1ps

module tb_uwasic_onboarding_eliot_tong;

    logic clk;
    logic rst_n;
    logic sclk;
    logic copi;
    logic ncs;

    int n_cmp;
    int n_fail;

    uwasic_onboarding_eliot_tong_if bus ();

    assign bus.ena    = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in  = {5'b00000, ncs, copi, sclk};

    uwasic_onboarding_eliot_tong dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [7:0]  exp_uo;
        logic [7:0]  exp_uio;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of word MSB first (bits past 16 are zero), 4 clk per SCLK phase.
    task automatic spi_shift(input logic [15:0] w, input int nbits, input bit release_ncs);
        ncs = 1'b0;
        clks(4);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15 - i] : 1'b0;
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        clks(4);
        if (release_ncs) ncs = 1'b1;
    endtask

    // Wait until uo_out[0] equals lvl; returns elapsed clk count.
    task automatic wait_level(input logic lvl, output int cycles);
        cycles = 0;
        while (bus.uo_out[0] !== lvl && cycles < 10000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Count samples of uo_out[0] differing from lvl over n clk.
    task automatic count_bad(input logic lvl, input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.uo_out[0] !== lvl) bad++;
        end
    endtask

    initial begin
        int hi;
        int lo;
        int bad;
        n_cmp  = 0;
        n_fail = 0;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        rst_n  = 1'b1;

        vecs[0]  = '{16'h80F0, 16, 8'hF0, 8'h00};
        vecs[1]  = '{16'h81CC, 16, 8'hF0, 8'hCC};
        vecs[2]  = '{16'hB0AA, 16, 8'hF0, 8'hCC}; // address 0x30
        vecs[3]  = '{16'h8011, 15, 8'hF0, 8'hCC}; // truncated
        vecs[4]  = '{16'h0033, 16, 8'hF0, 8'hCC}; // read frame
        vecs[5]  = '{16'h8022, 17, 8'hF0, 8'hCC}; // over-length
        vecs[6]  = '{16'h8577, 16, 8'hF0, 8'hCC}; // address 0x05
        vecs[7]  = '{16'hFF12, 16, 8'hF0, 8'hCC}; // address 0x7F
        vecs[8]  = '{16'h800F, 16, 8'h0F, 8'hCC};
        vecs[9]  = '{16'h8100, 16, 8'h0F, 8'h00};
        vecs[10] = '{16'h8155, 16, 8'h0F, 8'h55};
        vecs[11] = '{16'h80A5, 16, 8'hA5, 8'h55};

        // Reset
        clks(3);
        check("rst_uo_during", bus.uo_out, 8'h00);
        check("rst_oe_during", bus.uio_oe, 8'hFF);
        clks(2);
        rst_n = 1'b0;
        clks(4);
        check("rst_uo", bus.uo_out, 8'h00);
        check("rst_uio", bus.uio_out, 8'h00);
        check("rst_oe", bus.uio_oe, 8'hFF);

        // Table of frames
        for (int v = 0; v < 12; v++) begin
            spi_shift(vecs[v].word, vecs[v].nbits, 1'b1);
            clks(4);
            check($sformatf("vec%0d_uo", v), bus.uo_out, vecs[v].exp_uo);
            check($sformatf("vec%0d_uio", v), bus.uio_out, vecs[v].exp_uio);
            clks(2);
        end

        // Write latency: old value after 3 clk, new value after 4
        spi_shift(16'h8033, 16, 1'b1);
        clks(3);
        check("lat_3clk_old", bus.uo_out, 8'hA5);
        clks(1);
        check("lat_4clk_new", bus.uo_out, 8'h33);
        clks(2);

        // Back-to-back frames with nCS re-asserted right away
        spi_shift(16'h8001, 16, 1'b1);
        clks(2);
        spi_shift(16'h8100, 16, 1'b1);
        clks(4);
        check("b2b_uo", bus.uo_out, 8'h01);
        check("b2b_uio", bus.uio_out, 8'h00);

`ifdef PWM_EN
        // 50% PWM on ch0
        spi_shift(16'h8201, 16, 1'b1);
        clks(4);
        check("pwm_duty0_low", bus.uo_out, 8'h00);
        spi_shift(16'h8480, 16, 1'b1);
        wait_level(1'b0, hi);
        wait_level(1'b1, hi);
        check("pwm_sync_timeout", (hi < 10000) ? 32'd1 : 32'd0, 32'd1);
        wait_level(1'b0, hi);
        wait_level(1'b1, lo);
        check("pwm_high_time", hi, 32'd1664);
        n_cmp++;
        if ((hi + lo) < 3327 || (hi + lo) > 3329) begin
            n_fail++;
            $display("FAIL pwm_period: got %0d expected 3328", hi + lo);
        end

        // Duty extremes
        spi_shift(16'h8400, 16, 1'b1);
        clks(4);
        count_bad(1'b0, 6656, bad);
        check("pwm_duty00_const0", bad, 32'd0);
        spi_shift(16'h84FF, 16, 1'b1);
        clks(4);
        count_bad(1'b1, 6656, bad);
        check("pwm_dutyFF_const1", bad, 32'd0);
`else
        // PWM addresses are ignored: ch0 stays steady high
        spi_shift(16'h8201, 16, 1'b1);
        spi_shift(16'h8480, 16, 1'b1);
        spi_shift(16'h8301, 16, 1'b1);
        clks(4);
        check("nopwm_uo", bus.uo_out, 8'h01);
        check("nopwm_uio", bus.uio_out, 8'h00);
        count_bad(1'b1, 3400, bad);
        check("nopwm_const1", bad, 32'd0);
`endif

        // Reset in the middle of a frame
        spi_shift(16'h80FF, 8, 1'b0);
        rst_n = 1'b1;
        clks(5);
        check("midrst_uo_during", bus.uo_out, 8'h00);
        ncs = 1'b1;
        clks(1);
        rst_n = 1'b0;
        clks(6);
        check("midrst_uo_after", bus.uo_out, 8'h00);
        check("midrst_uio_after", bus.uio_out, 8'h00);
        spi_shift(16'h8055, 16, 1'b1);
        clks(4);
        check("midrst_write_uo", bus.uo_out, 8'h55);
        check("midrst_write_uio", bus.uio_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
